mem_bus_ctrl: RTL and testbench

- Bus controller between the MIPS datapath load/store port and the 128-word single-port memory. The memory has chip select, write enable, a word address and a shared bidirectional 32-bit data bus, and it samples on the falling edge.
- Accepts byte-addressed requests through a valid/ready handshake and converts them to word accesses.
- Merges byte-enable writes using read-modify-write.
- Owns tri-state control of the shared bus and returns one response per request.

---
 rtl/mem_bus_ctrl.sv | 159 +++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// Bus controller between the datapath load/store port and a single-port,
// falling-edge-sampled word memory. Converts byte-addressed requests into
// word accesses, merges partial stores with read-modify-write and owns the
// tri-state enable of the shared data bus.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request; latch it on the handshake
// READ  | memory read cycle (CS=1, WE=0), bus released, capture at close
// WRITE | memory write cycle (CS=1, WE=1), controller drives the bus
// RESP  | completion; response strobe is registered out of this state
// ERR   | rejected request; error response registered out of this state
module mem_bus_ctrl #(
  parameter int DEPTH = 128,
  parameter int IDX_W = 7
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        CS,
  output logic        WE,
  output logic [31:0] ADDR,
  inout  wire  [31:0] Mem_Bus
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, RESP, ERR} state_t;

  state_t state, state_d;

  logic             ready_en;
  logic             rmw_q;
  logic             load_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rd_q;
  logic [31:0]      wr_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] addr_q;

  logic             accept;
  logic             req_bad;
  logic [IDX_W-1:0] req_idx;
  logic [31:0]      merged;

  logic             cs_d;
  logic             we_d;
  logic [IDX_W-1:0] addr_d;
  logic             rsp_valid_d;
  logic             rsp_err_d;
  logic [31:0]      rsp_rdata_d;

  assign accept  = req_valid && req_ready;
  assign req_idx = req_addr[IDX_W+1:2];
  assign req_bad = (req_addr[1:0] != 2'b00) || (req_addr >= 32'(4 * DEPTH));

  // Lane merge for partial stores: enabled lanes from store data, rest from the read word.
  always_comb begin
    merged = '0;
    for (int n = 0; n < 4; n++)
      merged[8*n +: 8] = be_q[n] ? wdata_q[8*n +: 8] : Mem_Bus[8*n +: 8];
  end

  // Only the WRITE cycle drives the bus, so a read cycle can never see contention.
  assign Mem_Bus   = WE ? wr_q : 'z;
  assign req_ready = ready_en && (state == IDLE);
  assign ADDR      = {{(32-IDX_W){1'b0}}, addr_q};

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_bad)                state_d = ERR;
          else if (!req_we)           state_d = READ;
          else if (req_be == 4'h0)    state_d = RESP;
          else if (req_be == 4'hF)    state_d = WRITE;
          else                        state_d = READ;
        end
      end
      READ:    state_d = rmw_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; everything here is registered below so memory-side pins are glitch-free.
  always_comb begin
    cs_d        = (state_d == READ) || (state_d == WRITE);
    we_d        = (state_d == WRITE);
    addr_d      = (state == IDLE) ? req_idx : idx_q;
    rsp_valid_d = (state == RESP) || (state == ERR);
    rsp_err_d   = (state == ERR);
    rsp_rdata_d = ((state == RESP) && load_q) ? rd_q : 32'h0;
  end

  // Registered memory-side and response outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ready_en  <= 1'b0;
      CS        <= 1'b0;
      WE        <= 1'b0;
      addr_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      ready_en  <= 1'b1;
      CS        <= cs_d;
      WE        <= we_d;
      if (cs_d) addr_q <= addr_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

  // Request latch, read capture and write-word construction.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rmw_q   <= 1'b0;
      load_q  <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      idx_q   <= '0;
    end else begin
      if (accept) begin
        rmw_q   <= req_we && (req_be != 4'h0) && (req_be != 4'hF);
        load_q  <= !req_we;
        be_q    <= req_be;
        wdata_q <= req_wdata;
        wr_q    <= req_wdata;
        idx_q   <= req_idx;
      end else if (state == READ) begin
        rd_q <= Mem_Bus;
        if (rmw_q) wr_q <= merged;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl with a falling-edge word memory on the
// shared bus and a request-level reference model.
module tb_mem_bus_ctrl;

  localparam int DEPTH = 128;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        CS;
  logic        WE;
  logic [31:0] ADDR;
  wire  [31:0] mem_bus;

  mem_bus_ctrl #(.DEPTH(DEPTH), .IDX_W(7)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .CS(CS), .WE(WE), .ADDR(ADDR), .Mem_Bus(mem_bus)
  );

  always #5 CLK = ~CLK;

  // Attached memory: reads are combinational while CS=1/WE=0, writes land on the falling edge.
  logic [31:0] mem [DEPTH];
  logic [31:0] mem_dout;
  assign mem_dout = mem[ADDR[6:0]];
  assign mem_bus  = (CS && !WE) ? mem_dout : 32'hz;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5AC3C3;
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
    forever begin
      @(negedge CLK);
      if (CS && WE) mem[ADDR[6:0]] <= mem_bus;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    int          cs_n;
    int          we_n;
    logic [31:0] idx;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model_mem [DEPTH];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_acc = 0;
  int          n_rsp = 0;
  int          cs_cnt = 0;
  int          we_cnt = 0;
  bit          ignore_cs = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: the outcome of one request, straight from the request-level rules.
  task automatic model(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, output exp_t e);
    int idx;
    logic [31:0] w;
    idx = int'(addr / 4) % DEPTH;
    e.rdata = 0; e.err = 0; e.cs_n = 0; e.we_n = 0; e.idx = 32'(idx);
    if ((addr % 4) != 0 || addr >= 4 * DEPTH) begin
      e.err = 1; e.lat = 2;
    end else if (!we) begin
      e.rdata = model_mem[idx]; e.lat = 3; e.cs_n = 1;
    end else if (be == 0) begin
      e.lat = 2;
    end else begin
      w = model_mem[idx];
      for (int n = 0; n < 4; n++) if (be[n]) w[8*n +: 8] = wdata[8*n +: 8];
      model_mem[idx] = w;
      e.we_n = 1;
      if (be == 4'hF) begin e.lat = 3; e.cs_n = 1; end
      else            begin e.lat = 4; e.cs_n = 2; end
    end
  endtask

  // Drive one request from a falling edge; it is accepted at the next rising edge with req_ready.
  task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit hold);
    exp_t e;
    req_valid = 1; req_we = we; req_be = be; req_addr = addr; req_wdata = wdata;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        model(we, be, addr, wdata, e);
        e.acc = cyc + 1;
        q.push_back(e);
        n_acc++;
        @(posedge CLK);
        @(negedge CLK);
        chk("ready_after_accept", {31'b0, req_ready}, 32'd0);
        if (!hold) req_valid = 0;
        return;
      end
      @(negedge CLK);
    end
    chk("accept_timeout", 32'd1, 32'd0);
    req_valid = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge CLK);
    chk("drain_timeout", 32'(q.size()), 32'd0);
    @(negedge CLK);
  endtask

  // Monitor: pops the scoreboard on each response and checks memory-side activity.
  always @(negedge CLK) begin
    if (!RST_N) begin
      cs_cnt = 0; we_cnt = 0;
    end else begin
      if (CS && !ignore_cs) begin
        cs_cnt++;
        if (WE) we_cnt++;
        if (q.size() != 0) chk("addr", ADDR, q[0].idx);
        else               chk("cs_without_request", 32'd1, 32'd0);
      end
      if (CS && !WE) chk("bus_contention", mem_bus, mem_dout);
      if (rsp_valid) begin
        if (q.size() == 0) begin
          chk("spurious_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
          chk("latency", 32'(cyc + 1 - e.acc), 32'(e.lat));
          chk("cs_cycles", 32'(cs_cnt), 32'(e.cs_n));
          chk("we_cycles", 32'(we_cnt), 32'(e.we_n));
          n_rsp++;
        end
        cs_cnt = 0; we_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = init_word(i);

    // Reset state.
    #3;
    chk("rst_cs", {31'b0, CS}, 32'd0);
    chk("rst_we", {31'b0, WE}, 32'd0);
    chk("rst_addr", ADDR, 32'd0);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1;
    @(negedge CLK);
    @(negedge CLK);
    chk("ready_after_release", {31'b0, req_ready}, 32'd1);

    // Full store then load.
    issue(1, 4'hF, 32'h10, 32'hDEADBEEF, 0); wait_idle();
    issue(0, 4'h0, 32'h10, 32'h0, 0);        wait_idle();
    // Partial store with RMW then load back: expect DE22BE44.
    issue(1, 4'b0101, 32'h10, 32'h11223344, 0); wait_idle();
    issue(0, 4'hF, 32'h10, 32'h0, 0);           wait_idle();
    chk("rmw_word4", model_mem[4], 32'hDE22BE44);
    // Misaligned and out-of-range loads.
    issue(0, 4'hF, 32'h13, 32'h0, 0);  wait_idle();
    issue(0, 4'hF, 32'h200, 32'h0, 0); wait_idle();
    // Empty store then read back the untouched word.
    issue(1, 4'h0, 32'h20, 32'hFFFFFFFF, 0); wait_idle();
    issue(0, 4'h0, 32'h20, 32'h0, 0);        wait_idle();
    // Three back-to-back loads with req_valid held high.
    issue(0, 4'h0, 32'h10, 32'h0, 1);
    issue(0, 4'h0, 32'h20, 32'h0, 1);
    issue(0, 4'h0, 32'h30, 32'h0, 0);
    wait_idle();
    chk("b2b_rsp_count", 32'(n_rsp), 32'(n_acc));

    // Reset during the READ of an RMW: no response, target word untouched.
    ignore_cs = 1;
    req_valid = 1; req_we = 1; req_be = 4'b0011; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge CLK);
    @(posedge CLK);
    #2;
    chk("rmw_in_read_cs", {31'b0, CS}, 32'd1);
    RST_N = 0;
    req_valid = 0;
    #1;
    chk("midrst_cs", {31'b0, CS}, 32'd0);
    chk("midrst_we", {31'b0, WE}, 32'd0);
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midrst_ready", {31'b0, req_ready}, 32'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1;
    ignore_cs = 0;
    @(negedge CLK);
    @(negedge CLK);
    chk("ready_after_midrst", {31'b0, req_ready}, 32'd1);
    chk("midrst_word16", mem[16], model_mem[16]);
    chk("midrst_no_rsp", 32'(n_rsp), 32'(n_acc));

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      int sel;
      logic [3:0] be;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      a = ($urandom_range(0, 4*DEPTH-1)) | 32'd1;
      else if (sel == 1) a = ($urandom | 32'h200) & ~32'd3;
      else               a = 32'($urandom_range(0, DEPTH-1)) * 4;
      case ($urandom_range(0, 3))
        0:       be = 4'h0;
        1:       be = 4'hF;
        default: be = 4'($urandom);
      endcase
      issue(1'($urandom), be, a, $urandom, 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 0;
        repeat ($urandom_range(1, 3)) @(negedge CLK);
      end
    end
    req_valid = 0;
    wait_idle();
    chk("total_rsp_count", 32'(n_rsp), 32'(n_acc));
    for (int i = 0; i < DEPTH; i++) chk("final_mem", mem[i], model_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
